sat_bin_xfer: RTL

SAT_BIN_XFER -- requirements
Module: sat_bin_xfer

---
 rtl/sat_bin_pkg.sv | 22 ++
 rtl/xfer_idx_cnt.sv | 29 ++
 rtl/sat_bin_xfer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sat_bin_pkg.sv
// Shared definitions for the SAT bin transfer controller: FSM encoding and
// bin-store region selectors.
package sat_bin_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LD_C,
        LD_VS,
        LD_LS,
        START,
        WAIT,
        ST_C,
        ST_VS,
        ST_LS,
        DONE
    } xfer_state_e;

    localparam logic [1:0] SEL_CLAUSE = 2'd0;
    localparam logic [1:0] SEL_VAR    = 2'd1;
    localparam logic [1:0] SEL_LVL    = 2'd2;

endpackage

// File: rtl/xfer_idx_cnt.sv
// Index counter for sequencing clause load/store; raises last when the
// count equals the limit chosen by the controller for the current phase.
module xfer_idx_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign last = (cnt == limit);

endmodule

// File: rtl/sat_bin_xfer.sv
// Moves one bin between the bin store and the SAT engine: load clauses and
// states, run the engine, latch its verdict, then write everything back.
module sat_bin_xfer
    import sat_bin_pkg::*;
#(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_MEM        = WIDTH_VAR_STATES * NUM_VARS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic [WIDTH_BIN_ID-1:0]              bin_num_i,
    input  logic [WIDTH_LVL-1:0]                 load_lvl_i,
    input  logic [WIDTH_LVL-1:0]                 base_lvl_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 sat_o,
    output logic                                 unsat_o,
    output logic [WIDTH_LVL-1:0]                 cur_lvl_o,
    output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0]              bkt_bin_o,
    output logic                                 mem_rd_o,
    output logic                                 mem_wr_o,
    output logic [1:0]                           mem_sel_o,
    output logic [2:0]                           mem_idx_o,
    output logic [WIDTH_MEM-1:0]                 mem_wdata_o,
    input  logic [WIDTH_MEM-1:0]                 mem_rdata_i,
    output logic                                 eng_start_o,
    input  logic                                 eng_done_i,
    output logic [WIDTH_BIN_ID-1:0]              eng_bin_num_o,
    output logic [WIDTH_LVL-1:0]                 eng_load_lvl_o,
    output logic [WIDTH_LVL-1:0]                 eng_base_lvl_o,
    output logic                                 eng_base_lvl_en_o,
    input  logic                                 eng_sat_i,
    input  logic                                 eng_unsat_i,
    input  logic [WIDTH_LVL-1:0]                 eng_cur_lvl_i,
    input  logic [WIDTH_LVL-1:0]                 eng_bkt_lvl_i,
    input  logic [WIDTH_BIN_ID-1:0]              eng_bkt_bin_i,
    output logic [NUM_CLAUSES-1:0]               wr_carray_o,
    output logic [NUM_CLAUSES-1:0]               rd_carray_o,
    output logic [NUM_VARS*2-1:0]                clause_o,
    input  logic [NUM_VARS*2-1:0]                clause_i,
    output logic [NUM_VARS-1:0]                  wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] var_states_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] var_states_i,
    output logic [NUM_LVLS-1:0]                  wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i
);

    localparam int           CW      = $clog2(NUM_CLAUSES + 1);
    localparam logic [CW-1:0] LAST_LD = CW'(NUM_CLAUSES);
    localparam logic [CW-1:0] LAST_ST = CW'(NUM_CLAUSES - 1);

    xfer_state_e    state, state_next;
    logic [CW-1:0]  cnt, cnt_limit;
    logic           cnt_en, cnt_clr, cnt_last;

    xfer_idx_cnt #(.WIDTH(CW)) u_idx_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_limit),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // Every phase change restarts the index so each phase counts from zero.
    assign cnt_clr = (state_next != state);
    assign busy_o  = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            eng_bin_num_o  <= '0;
            eng_load_lvl_o <= '0;
            eng_base_lvl_o <= '0;
            sat_o          <= 1'b0;
            unsat_o        <= 1'b0;
            cur_lvl_o      <= '0;
            bkt_lvl_o      <= '0;
            bkt_bin_o      <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start_i) begin
                eng_bin_num_o  <= bin_num_i;
                eng_load_lvl_o <= load_lvl_i;
                eng_base_lvl_o <= base_lvl_i;
            end
            if (state == WAIT && eng_done_i) begin
                sat_o     <= eng_sat_i;
                unsat_o   <= eng_unsat_i;
                cur_lvl_o <= eng_cur_lvl_i;
                bkt_lvl_o <= eng_bkt_lvl_i;
                bkt_bin_o <= eng_bkt_bin_i;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next        = state;
        cnt_en            = 1'b0;
        cnt_limit         = '0;
        done_o            = 1'b0;
        mem_rd_o          = 1'b0;
        mem_wr_o          = 1'b0;
        mem_sel_o         = SEL_CLAUSE;
        mem_idx_o         = '0;
        mem_wdata_o       = '0;
        eng_start_o       = 1'b0;
        eng_base_lvl_en_o = 1'b0;
        wr_carray_o       = '0;
        rd_carray_o       = '0;
        clause_o          = '0;
        wr_var_states_o   = '0;
        var_states_o      = '0;
        wr_lvl_states_o   = '0;
        lvl_states_o      = '0;

        case (state)
            IDLE: begin
                if (start_i) state_next = LD_C;
            end
            LD_C: begin
                // Reads run one cycle ahead of the matching engine write.
                cnt_en    = 1'b1;
                cnt_limit = LAST_LD;
                if (cnt != LAST_LD) begin
                    mem_rd_o  = 1'b1;
                    mem_idx_o = 3'(cnt);
                end
                if (cnt != '0) begin
                    wr_carray_o = NUM_CLAUSES'(1) << (cnt - CW'(1));
                    clause_o    = mem_rdata_i[NUM_VARS*2-1:0];
                end
                if (cnt_last) state_next = LD_VS;
            end
            LD_VS: begin
                cnt_en    = 1'b1;
                cnt_limit = CW'(1);
                if (!cnt_last) begin
                    mem_rd_o  = 1'b1;
                    mem_sel_o = SEL_VAR;
                end else begin
                    wr_var_states_o = '1;
                    var_states_o    = mem_rdata_i[WIDTH_VAR_STATES*NUM_VARS-1:0];
                    state_next      = LD_LS;
                end
            end
            LD_LS: begin
                cnt_en    = 1'b1;
                cnt_limit = CW'(1);
                if (!cnt_last) begin
                    mem_rd_o  = 1'b1;
                    mem_sel_o = SEL_LVL;
                end else begin
                    wr_lvl_states_o   = '1;
                    lvl_states_o      = mem_rdata_i[WIDTH_LVL_STATES*NUM_LVLS-1:0];
                    eng_base_lvl_en_o = 1'b1;
                    state_next        = START;
                end
            end
            START: begin
                eng_start_o = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                if (eng_done_i) state_next = ST_C;
            end
            ST_C: begin
                cnt_en      = 1'b1;
                cnt_limit   = LAST_ST;
                rd_carray_o = NUM_CLAUSES'(1) << cnt;
                mem_wr_o    = 1'b1;
                mem_idx_o   = 3'(cnt);
                mem_wdata_o = WIDTH_MEM'(clause_i);
                if (cnt_last) state_next = ST_VS;
            end
            ST_VS: begin
                mem_wr_o    = 1'b1;
                mem_sel_o   = SEL_VAR;
                mem_wdata_o = WIDTH_MEM'(var_states_i);
                state_next  = ST_LS;
            end
            ST_LS: begin
                mem_wr_o    = 1'b1;
                mem_sel_o   = SEL_LVL;
                mem_wdata_o = WIDTH_MEM'(lvl_states_i);
                state_next  = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
